// File: rtl/warp_scoreboard.sv
// warp_scoreboard
//   Per-warp register scoreboard for the SM issue path. It tracks in-flight
//   destination writes for every warp. It checks each warp's buffered next
//   instruction for RAW/WAW hazards and outstanding-write capacity, and
//   produces the ready_mask consumed by the round-robin arbiter.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ibuf_valid[W]     warp holds a decoded next instruction
//   ibuf_use[3W]      per warp {dst_used, src1_used, src0_used}
//   ibuf_src0/src1/dst[RB*W]  per-warp register indices
//   issue_valid/idx   registered grant from the arbiter (marks dst pending)
//   wb_valid/warp/reg writeback completion (clears pending)
//   ready_mask[W]     warp may issue this cycle
//   pend_cnt_flat[4W] per-warp outstanding-write count
//   err_spurious_wb   sticky: writeback to a non-pending register
//   err_hazard_issue  sticky: issue of a warp that was not ready
module warp_scoreboard #(
  parameter int W    = 32,
  parameter int R    = 64,
  parameter int MAXP = 7,
  localparam int RB  = $clog2(R),
  localparam int WB  = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    ibuf_valid,
  input  logic [3*W-1:0]  ibuf_use,
  input  logic [RB*W-1:0] ibuf_src0,
  input  logic [RB*W-1:0] ibuf_src1,
  input  logic [RB*W-1:0] ibuf_dst,
  input  logic            issue_valid,
  input  logic [WB-1:0]   issue_idx,
  input  logic            wb_valid,
  input  logic [WB-1:0]   wb_warp,
  input  logic [RB-1:0]   wb_reg,
  output logic [W-1:0]    ready_mask,
  output logic [4*W-1:0]  pend_cnt_flat,
  output logic            err_spurious_wb,
  output logic            err_hazard_issue
);

  logic [W-1:0] hazard_free;
  logic [W-1:0] wb_pend_hit;

  for (genvar g = 0; g < W; g++) begin : g_warp
    logic [R-1:0]  pend;
    logic [3:0]    cnt;
    logic [RB-1:0] src0, src1, dst;
    logic [2:0]    use_bits;
    logic          issue_sel, wb_sel, set_dst, inc, dec;

    assign src0     = ibuf_src0[RB*g +: RB];
    assign src1     = ibuf_src1[RB*g +: RB];
    assign dst      = ibuf_dst[RB*g +: RB];
    assign use_bits = ibuf_use[3*g +: 3];

    assign issue_sel = issue_valid && (issue_idx == WB'(g));
    assign wb_sel    = wb_valid && (wb_warp == WB'(g));

    // Readiness without the in-flight issue mask; the same term grades an
    // actual issue for the hazard error.
    assign hazard_free[g] = ibuf_valid[g]
                            && !(use_bits[0] && pend[src0])
                            && !(use_bits[1] && pend[src1])
                            && !(use_bits[2] && pend[dst])
                            && (cnt < 4'(MAXP));

    // The warp being issued this cycle has not updated state yet.
    assign ready_mask[g] = hazard_free[g] && !issue_sel;

    assign wb_pend_hit[g] = pend[wb_reg];

    assign set_dst = issue_sel && use_bits[2];
    assign inc     = set_dst && (cnt != 4'hF);
    assign dec     = wb_sel && pend[wb_reg];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend <= '0;
        cnt  <= '0;
      end else begin
        // Set is written last so it wins when retire and reissue share a register.
        if (dec)     pend[wb_reg] <= 1'b0;
        if (set_dst) pend[dst]    <= 1'b1;
        cnt <= cnt + {3'b000, inc} - {3'b000, dec};
      end
    end

    assign pend_cnt_flat[4*g +: 4] = cnt;
  end

  logic spurious_now, hazard_now;
  assign spurious_now = wb_valid && !wb_pend_hit[wb_warp];
  assign hazard_now   = issue_valid && !hazard_free[issue_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_spurious_wb  <= 1'b0;
      err_hazard_issue <= 1'b0;
    end else begin
      if (spurious_now) err_spurious_wb  <= 1'b1;
      if (hazard_now)   err_hazard_issue <= 1'b1;
    end
  end

endmodule

// File: tb/tb_warp_scoreboard.sv
module tb_warp_scoreboard;
  localparam int W = 32, R = 64, MAXP = 7, RB = 6, WB = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    ibuf_valid;
  logic [3*W-1:0]  ibuf_use;
  logic [RB*W-1:0] ibuf_src0, ibuf_src1, ibuf_dst;
  logic            issue_valid;
  logic [WB-1:0]   issue_idx;
  logic            wb_valid;
  logic [WB-1:0]   wb_warp;
  logic [RB-1:0]   wb_reg;
  logic [W-1:0]    ready_mask;
  logic [4*W-1:0]  pend_cnt_flat;
  logic            err_spurious_wb, err_hazard_issue;

  int n_checks = 0;
  int n_fail   = 0;

  logic          v_valid [W];
  logic [2:0]    v_use   [W];
  logic [RB-1:0] v_s0    [W];
  logic [RB-1:0] v_s1    [W];
  logic [RB-1:0] v_dst   [W];

  warp_scoreboard #(.W(W), .R(R), .MAXP(MAXP)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibuf_valid(ibuf_valid), .ibuf_use(ibuf_use),
    .ibuf_src0(ibuf_src0), .ibuf_src1(ibuf_src1), .ibuf_dst(ibuf_dst),
    .issue_valid(issue_valid), .issue_idx(issue_idx),
    .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_reg(wb_reg),
    .ready_mask(ready_mask), .pend_cnt_flat(pend_cnt_flat),
    .err_spurious_wb(err_spurious_wb), .err_hazard_issue(err_hazard_issue)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_ibuf();
    for (int w = 0; w < W; w++) begin
      ibuf_valid[w]          = v_valid[w];
      ibuf_use[3*w +: 3]     = v_use[w];
      ibuf_src0[RB*w +: RB]  = v_s0[w];
      ibuf_src1[RB*w +: RB]  = v_s1[w];
      ibuf_dst[RB*w +: RB]   = v_dst[w];
    end
  endtask

  task automatic set_warp(input int w, input logic vld, input logic [2:0] u,
                          input int s0, input int s1, input int d);
    v_valid[w] = vld;
    v_use[w]   = u;
    v_s0[w]    = s0[RB-1:0];
    v_s1[w]    = s1[RB-1:0];
    v_dst[w]   = d[RB-1:0];
    pack_ibuf();
  endtask

  function automatic logic [3:0] cnt_of(input int w);
    return pend_cnt_flat[4*w +: 4];
  endfunction

  task automatic clear_warps();
    for (int w = 0; w < W; w++) begin
      v_valid[w] = 1'b0; v_use[w] = 3'b000;
      v_s0[w] = '0; v_s1[w] = '0; v_dst[w] = '0;
    end
    pack_ibuf();
  endtask

  task automatic do_reset();
    issue_valid = 1'b0; issue_idx = '0;
    wb_valid = 1'b0; wb_warp = '0; wb_reg = '0;
    clear_warps();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_idx = '0;
    wb_valid = 1'b0; wb_warp = '0; wb_reg = '0;
    for (int w = 0; w < W; w++) begin
      v_valid[w] = 1'b1;
      v_use[w]   = 3'($urandom_range(0, 7));
      v_s0[w]    = RB'($urandom_range(0, R-1));
      v_s1[w]    = RB'($urandom_range(0, R-1));
      v_dst[w]   = RB'($urandom_range(0, R-1));
    end
    pack_ibuf();
    #2;
    n_checks++;
    if (ready_mask !== 32'hFFFF_FFFF) begin
      $display("FAIL reset_ready: got %h expected ffffffff", ready_mask); n_fail++;
    end
    n_checks++;
    if (pend_cnt_flat !== '0) begin
      $display("FAIL reset_cnt: got %h expected 0", pend_cnt_flat); n_fail++;
    end
    n_checks++;
    if (err_spurious_wb !== 1'b0 || err_hazard_issue !== 1'b0) begin
      $display("FAIL reset_err: got %b%b expected 00", err_spurious_wb, err_hazard_issue); n_fail++;
    end
    #1;
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if (ready_mask !== 32'hFFFF_FFFF) begin
      $display("FAIL post_reset_ready: got %h expected ffffffff", ready_mask); n_fail++;
    end
  endtask

  task automatic test_raw();
    do_reset();
    set_warp(3, 1'b1, 3'b100, 0, 0, 5);
    #1;
    n_checks++;
    if (ready_mask[3] !== 1'b1) begin
      $display("FAIL raw_pre_ready: got %b expected 1", ready_mask[3]); n_fail++;
    end
    step();
    issue_valid = 1'b1; issue_idx = 5'd3;
    #1;
    n_checks++;
    if (ready_mask[3] !== 1'b0) begin
      $display("FAIL raw_issue_mask: got %b expected 0", ready_mask[3]); n_fail++;
    end
    step();
    issue_valid = 1'b0;
    set_warp(3, 1'b1, 3'b001, 5, 0, 10);
    #1;
    n_checks++;
    if (ready_mask[3] !== 1'b0) begin
      $display("FAIL raw_hazard: got %b expected 0", ready_mask[3]); n_fail++;
    end
    n_checks++;
    if (cnt_of(3) !== 4'd1) begin
      $display("FAIL raw_cnt_up: got %0d expected 1", cnt_of(3)); n_fail++;
    end
    step();
    wb_valid = 1'b1; wb_warp = 5'd3; wb_reg = 6'd5;
    #1;
    n_checks++;
    if (ready_mask[3] !== 1'b0) begin
      $display("FAIL raw_no_bypass: got %b expected 0", ready_mask[3]); n_fail++;
    end
    step();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (ready_mask[3] !== 1'b1) begin
      $display("FAIL raw_wb_ready: got %b expected 1", ready_mask[3]); n_fail++;
    end
    n_checks++;
    if (cnt_of(3) !== 4'd0) begin
      $display("FAIL raw_cnt_down: got %0d expected 0", cnt_of(3)); n_fail++;
    end
  endtask

  task automatic test_capacity();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_warp(0, 1'b1, 3'b100, 0, 0, i);
      issue_valid = 1'b1; issue_idx = 5'd0;
      step();
    end
    issue_valid = 1'b0;
    set_warp(0, 1'b1, 3'b000, 20, 21, 22);
    #1;
    n_checks++;
    if (cnt_of(0) !== 4'd7) begin
      $display("FAIL cap_cnt: got %0d expected 7", cnt_of(0)); n_fail++;
    end
    n_checks++;
    if (ready_mask[0] !== 1'b0) begin
      $display("FAIL cap_full: got %b expected 0", ready_mask[0]); n_fail++;
    end
    n_checks++;
    if (err_hazard_issue !== 1'b0) begin
      $display("FAIL cap_no_err: got %b expected 0", err_hazard_issue); n_fail++;
    end
    wb_valid = 1'b1; wb_warp = 5'd0; wb_reg = 6'd0;
    step();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (ready_mask[0] !== 1'b1) begin
      $display("FAIL cap_free: got %b expected 1", ready_mask[0]); n_fail++;
    end
    n_checks++;
    if (cnt_of(0) !== 4'd6) begin
      $display("FAIL cap_cnt_dec: got %0d expected 6", cnt_of(0)); n_fail++;
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_warp(2, 1'b1, 3'b100, 0, 0, 9);
    issue_valid = 1'b1; issue_idx = 5'd2;
    step();
    issue_valid = 1'b0;
    #1;
    n_checks++;
    if (cnt_of(2) !== 4'd1) begin
      $display("FAIL same_pre_cnt: got %0d expected 1", cnt_of(2)); n_fail++;
    end
    issue_valid = 1'b1; issue_idx = 5'd2;
    wb_valid = 1'b1; wb_warp = 5'd2; wb_reg = 6'd9;
    step();
    issue_valid = 1'b0; wb_valid = 1'b0;
    set_warp(2, 1'b1, 3'b001, 9, 0, 0);
    #1;
    n_checks++;
    if (cnt_of(2) !== 4'd1) begin
      $display("FAIL same_cnt: got %0d expected 1", cnt_of(2)); n_fail++;
    end
    n_checks++;
    if (ready_mask[2] !== 1'b0) begin
      $display("FAIL same_pend_kept: got %b expected 0", ready_mask[2]); n_fail++;
    end
    n_checks++;
    if (err_spurious_wb !== 1'b0) begin
      $display("FAIL same_no_spurious: got %b expected 0", err_spurious_wb); n_fail++;
    end
    wb_valid = 1'b1; wb_warp = 5'd2; wb_reg = 6'd9;
    step();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (ready_mask[2] !== 1'b1 || cnt_of(2) !== 4'd0) begin
      $display("FAIL same_retire: got ready %b cnt %0d expected ready 1 cnt 0",
               ready_mask[2], cnt_of(2)); n_fail++;
    end
  endtask

  task automatic test_errors();
    do_reset();
    wb_valid = 1'b1; wb_warp = 5'd7; wb_reg = 6'd1;
    step();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (err_spurious_wb !== 1'b1) begin
      $display("FAIL spurious_set: got %b expected 1", err_spurious_wb); n_fail++;
    end
    n_checks++;
    if (cnt_of(7) !== 4'd0) begin
      $display("FAIL spurious_cnt: got %0d expected 0", cnt_of(7)); n_fail++;
    end
    step();
    step();
    n_checks++;
    if (err_spurious_wb !== 1'b1) begin
      $display("FAIL spurious_sticky: got %b expected 1", err_spurious_wb); n_fail++;
    end
    set_warp(4, 1'b1, 3'b100, 0, 0, 2);
    issue_valid = 1'b1; issue_idx = 5'd4;
    step();
    issue_valid = 1'b0;
    set_warp(4, 1'b1, 3'b101, 2, 0, 3);
    #1;
    n_checks++;
    if (err_hazard_issue !== 1'b0 || ready_mask[4] !== 1'b0) begin
      $display("FAIL hazard_pre: got err %b ready %b expected err 0 ready 0",
               err_hazard_issue, ready_mask[4]); n_fail++;
    end
    issue_valid = 1'b1; issue_idx = 5'd4;
    step();
    issue_valid = 1'b0;
    #1;
    n_checks++;
    if (err_hazard_issue !== 1'b1) begin
      $display("FAIL hazard_set: got %b expected 1", err_hazard_issue); n_fail++;
    end
    n_checks++;
    if (cnt_of(4) !== 4'd2) begin
      $display("FAIL hazard_update_applied: got %0d expected 2", cnt_of(4)); n_fail++;
    end
  endtask

  task automatic test_stress();
    bit            pend_m [W][R];
    int            cnt_m  [W];
    logic [W-1:0]  rdy_m;
    logic [4*W-1:0] cnt_flat_m;
    int            ptr, gnt_w, ww, rr;
    bit            gnt_v;
    do_reset();
    for (int w = 0; w < W; w++) begin
      cnt_m[w] = 0;
      for (int r = 0; r < R; r++) pend_m[w][r] = 1'b0;
    end
    ptr = 0; gnt_v = 1'b0; gnt_w = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // The granted warp keeps its instruction until it issues.
      for (int w = 0; w < W; w++) begin
        if (!(issue_valid && issue_idx == w)) begin
          v_valid[w] = ($urandom_range(0, 3) != 0);
          v_use[w]   = 3'($urandom_range(0, 7));
          v_s0[w]    = RB'($urandom_range(0, 7));
          v_s1[w]    = RB'($urandom_range(0, 7));
          v_dst[w]   = RB'($urandom_range(0, 7));
        end
      end
      pack_ibuf();
      wb_valid = 1'b0;
      for (int t = 0; t < 8; t++) begin
        ww = $urandom_range(0, W-1);
        rr = $urandom_range(0, 7);
        if (!wb_valid && pend_m[ww][rr]) begin
          wb_valid = 1'b1; wb_warp = WB'(ww); wb_reg = RB'(rr);
        end
      end
      #1;
      for (int w = 0; w < W; w++) begin
        rdy_m[w] = v_valid[w]
                   && !(v_use[w][0] && pend_m[w][v_s0[w]])
                   && !(v_use[w][1] && pend_m[w][v_s1[w]])
                   && !(v_use[w][2] && pend_m[w][v_dst[w]])
                   && (cnt_m[w] < MAXP)
                   && !(issue_valid && issue_idx == w);
        cnt_flat_m[4*w +: 4] = 4'(cnt_m[w]);
      end
      n_checks++;
      if (ready_mask !== rdy_m) begin
        $display("FAIL stress_ready cyc %0d: got %h expected %h", cyc, ready_mask, rdy_m); n_fail++;
      end
      n_checks++;
      if (pend_cnt_flat !== cnt_flat_m) begin
        $display("FAIL stress_cnt cyc %0d: got %h expected %h", cyc, pend_cnt_flat, cnt_flat_m); n_fail++;
      end
      if (cyc == 200) begin
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pend_cnt_flat !== '0 || err_spurious_wb !== 1'b0 || err_hazard_issue !== 1'b0) begin
          $display("FAIL stress_reset: got cnt %h errs %b%b expected 0", pend_cnt_flat,
                   err_spurious_wb, err_hazard_issue); n_fail++;
        end
        for (int w = 0; w < W; w++) begin
          cnt_m[w] = 0;
          for (int r = 0; r < R; r++) pend_m[w][r] = 1'b0;
        end
        issue_valid = 1'b0; wb_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        continue;
      end
      gnt_v = 1'b0;
      for (int k = 1; k <= W; k++) begin
        if (!gnt_v && rdy_m[(ptr + k) % W]) begin
          gnt_v = 1'b1; gnt_w = (ptr + k) % W;
        end
      end
      if (gnt_v) ptr = gnt_w;
      if (wb_valid && pend_m[wb_warp][wb_reg]) begin
        pend_m[wb_warp][wb_reg] = 1'b0;
        cnt_m[wb_warp]--;
      end
      if (issue_valid && v_use[issue_idx][2]) begin
        pend_m[issue_idx][v_dst[issue_idx]] = 1'b1;
        if (cnt_m[issue_idx] < 15) cnt_m[issue_idx]++;
      end
      step();
      issue_valid = gnt_v;
      issue_idx   = WB'(gnt_w);
    end
    issue_valid = 1'b0; wb_valid = 1'b0;
    step();
    n_checks++;
    if (err_hazard_issue !== 1'b0) begin
      $display("FAIL stress_no_hazard_issue: got %b expected 0", err_hazard_issue); n_fail++;
    end
    n_checks++;
    if (err_spurious_wb !== 1'b0) begin
      $display("FAIL stress_no_spurious: got %b expected 0", err_spurious_wb); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_capacity();
    test_same_cycle();
    test_errors();
    test_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
